bus_source_driver: RTL and testbench
====================================

// Module: bus_source_driver
// PURPOSE
//  Read side of the shared processor bus; the opposite end of the RIn-loaded R registers.
//  Selects one source (R0..R7, DIN or G) and snapshots it into a registered bus output.
//  Holds the value with a valid flag for a programmable number of cycles.
//  Sits between the register file/ALU result and the bus consumed by every RIn load.
// PARAMETERS
//  n            16  data width of bus and every source
//  HOLD_CYCLES  1   cycles BusValid stays high per transfer; legal range 1..15
// PORTS
//  Clock        in   1      system clock, rising edge
//  Resetn       in   1      asynchronous, active-low reset
//  RegR         in   8*n    R0..R7 contents, Rk at [k*n+n-1:k*n]
//  DIN          in   n      external data input source
//  G            in   n      ALU result register source
//  Rout         in   8      select Rk onto bus (one-hot expected)
//  Gout         in   1      select G onto bus
//  DINout       in   1      select DIN onto bus
//  ReqRead      in   1      request a bus transfer
//  BusWires     out  n      registered bus value
//  BusValid     out  1      BusWires holds a fresh transfer
//  Busy         out  1      transfer in progress (state != IDLE)
//  ConflictErr  out  1      sticky multi-select flag (tied 0 without macro)
// BEHAVIOUR
//  - Reset (Resetn=0, async): BusWires=0, BusValid=0, Busy=0, ConflictErr=0, cnt=0, state=IDLE.
//  - Any select = DINout | Gout | (|Rout). Priority when several are high:
//    DINout > Gout > Rout[0] > Rout[1] > ... > Rout[7].
//  - FSM states: IDLE and DRIVE.
//  - IDLE: at a rising edge with ReqRead=1 and any select=1:
//    BusWires <= selected source, BusValid <= 1, cnt <= HOLD_CYCLES-1, state <= DRIVE.
//    Latency is one edge: the sampled value is visible right after that edge.
//  - IDLE: ReqRead=1 with no select is ignored (no state change, BusValid stays 0).
//  - DRIVE, cnt != 0: cnt <= cnt-1 and BusWires is held.
//    ReqRead, select and source changes are ignored; the transfer is a snapshot.
//  - DRIVE, cnt == 0, ReqRead=1 with a select: back-to-back transfer.
//    Recapture the source and reload cnt; BusValid stays 1 with no bubble.
//  - DRIVE, cnt == 0, otherwise: BusValid <= 0, state <= IDLE.
//  - BusWires keeps its last driven value while BusValid=0; it never returns to 0 except on reset.
//  - Busy = (state == DRIVE), decoded combinationally from the state register.
//  - Resetn asserted mid-DRIVE aborts immediately to the reset values; no partial transfer completes.
//  - Widths: cnt is 4 bits. HOLD_CYCLES outside 1..15 is illegal; an elaboration-time check flags it.
// CONFIGURATION
//  BUS_CONFLICT_CHECK_EN defined:
//    - On any accepted transfer (IDLE or back-to-back) where more than one select bit is high,
//      ConflictErr <= 1 and stays set until reset.
//    - The transfer still completes using the priority order.
//  BUS_CONFLICT_CHECK_EN undefined:
//    - ConflictErr is constant 0.
//    - No popcount logic is built; the priority order still applies.
// TESTING
//  1. Reset: Resetn=0 with random inputs -> BusWires=0, BusValid=0, Busy=0, ConflictErr=0.
//  2. R3=16'h00A5, Rout=8'b0000_1000, ReqRead for 1 cycle, HOLD_CYCLES=1
//     -> BusWires=00A5 and BusValid=1 for exactly 1 cycle, then BusValid=0 with BusWires still 00A5.
//  3. HOLD_CYCLES=3, G=1234, Gout=1; change G to FFFF on the next cycle
//     -> BusWires stays 1234 for all 3 valid cycles and Busy=1 for all 3.
//  4. Back-to-back: DIN=0011 then R7=0022, with ReqRead held
//     -> BusValid is continuously 1 and BusWires goes 0011 -> 0022 with no gap.
//  5. DINout=1 and Rout=8'h01 together
//     -> BusWires=DIN; ConflictErr=1 only when BUS_CONFLICT_CHECK_EN is defined, and it stays sticky.
//  6. Resetn pulsed low mid-DRIVE -> all outputs return to 0 immediately; ReqRead with no select is ignored.

Source files
------------

// File: rtl/bus_source_driver.sv
// bus_source_driver: read side of the shared processor bus.
// Picks one of R0..R7, DIN or G and copies it into a registered bus output.
// BusValid stays high for HOLD_CYCLES cycles per transfer.
// Optional feature macro: BUS_CONFLICT_CHECK_EN. When it is defined, a sticky
// ConflictErr flag reports accepted transfers that had more than one select high.
module bus_source_driver #(
    parameter int n           = 16,
    parameter int HOLD_CYCLES = 1
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic [8*n-1:0] RegR,
    input  logic [n-1:0]   DIN,
    input  logic [n-1:0]   G,
    input  logic [7:0]     Rout,
    input  logic           Gout,
    input  logic           DINout,
    input  logic           ReqRead,
    output logic [n-1:0]   BusWires,
    output logic           BusValid,
    output logic           Busy,
    output logic           ConflictErr
);

    // The hold counter is 4 bits wide, so only 1..15 hold cycles are legal.
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("bus_source_driver: HOLD_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_RELOAD = 4'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [n-1:0] bus_q, bus_d;
    logic         valid_q, valid_d;

    logic         any_sel;
    logic         accept;
    logic [n-1:0] sel_data;

    assign any_sel = DINout | Gout | (|Rout);

    // A request is taken in IDLE, or on the last hold cycle of DRIVE (back-to-back).
    assign accept = ReqRead & any_sel & ((state_q == IDLE) | (cnt_q == 4'd0));

    // Priority source mux: DINout > Gout > Rout[0] > ... > Rout[7].
    always_comb begin
        sel_data = '0;
        for (int k = 7; k >= 0; k--) begin
            if (Rout[k]) sel_data = RegR[k*n +: n];
        end
        if (Gout)   sel_data = G;
        if (DINout) sel_data = DIN;
    end

    // Next-state logic: capture a snapshot, count down the hold, or release the bus.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bus_d   = sel_data;
                    valid_d = 1'b1;
                    cnt_d   = CNT_RELOAD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (accept) begin
                    bus_d   = sel_data;
                    valid_d = 1'b1;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM register: state, hold counter and the registered bus outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            bus_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
        end
    end

    assign BusWires = bus_q;
    assign BusValid = valid_q;
    assign Busy     = (state_q == DRIVE);

`ifdef BUS_CONFLICT_CHECK_EN
    logic conflict_q, conflict_d;
    logic multi_sel;

    assign multi_sel = ($countones({DINout, Gout, Rout}) > 1);

    // Sticky flag: set on any accepted transfer with more than one select high.
    always_comb begin
        conflict_d = conflict_q | (accept & multi_sel);
    end

    // Conflict flag register, cleared only by reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) conflict_q <= 1'b0;
        else         conflict_q <= conflict_d;
    end

    assign ConflictErr = conflict_q;
`else
    assign ConflictErr = 1'b0;
`endif

endmodule

// File: tb/tb_bus_source_driver.sv
// Scoreboard bench for bus_source_driver: two instances (HOLD_CYCLES=1 and 3)
// share one stimulus stream; a behavioural model predicts each cycle's outputs.
module tb_bus_source_driver;

    logic         Clock;
    logic         Resetn;
    logic [127:0] RegR;
    logic [15:0]  DIN;
    logic [15:0]  G;
    logic [7:0]   Rout;
    logic         Gout;
    logic         DINout;
    logic         ReqRead;

    logic [15:0]  bus_a, bus_b;
    logic         vld_a, vld_b;
    logic         busy_a, busy_b;
    logic         conf_a, conf_b;

    bus_source_driver #(.n(16), .HOLD_CYCLES(1)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .RegR(RegR), .DIN(DIN), .G(G),
        .Rout(Rout), .Gout(Gout), .DINout(DINout), .ReqRead(ReqRead),
        .BusWires(bus_a), .BusValid(vld_a), .Busy(busy_a), .ConflictErr(conf_a)
    );

    bus_source_driver #(.n(16), .HOLD_CYCLES(3)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .RegR(RegR), .DIN(DIN), .G(G),
        .Rout(Rout), .Gout(Gout), .DINout(DINout), .ReqRead(ReqRead),
        .BusWires(bus_b), .BusValid(vld_b), .Busy(busy_b), .ConflictErr(conf_b)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct packed {
        logic [15:0] bus;
        logic        vld;
        logic        busy;
        logic        conf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

`ifdef BUS_CONFLICT_CHECK_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    // Reference model: last value put on the bus, valid cycles left, sticky conflict.
    logic [15:0] m_bus [2];
    int          m_left[2];
    bit          m_conf[2];
    int          m_hold[2] = '{1, 3};

    function automatic logic [15:0] pick(input logic [15:0] din, input logic [15:0] g,
                                         input logic [127:0] regr, input logic [7:0] rout,
                                         input bit gout, input bit dinout);
        if (dinout) return din;
        if (gout)   return g;
        for (int k = 0; k < 8; k++) if (rout[k]) return regr[k*16 +: 16];
        return 16'h0;
    endfunction

    task automatic model_edge(input int i, input bit rst, input bit req,
                              input logic [15:0] din, input logic [15:0] g,
                              input logic [127:0] regr, input logic [7:0] rout,
                              input bit gout, input bit dinout);
        int nsel;
        nsel = $countones(rout) + int'(gout) + int'(dinout);
        if (!rst) begin
            m_bus[i] = 16'h0; m_left[i] = 0; m_conf[i] = 1'b0;
        end else if (m_left[i] > 1) begin
            m_left[i] = m_left[i] - 1;
        end else if (req && nsel > 0) begin
            m_bus[i]  = pick(din, g, regr, rout, gout, dinout);
            m_left[i] = m_hold[i];
            if (CONF_EN && nsel > 1) m_conf[i] = 1'b1;
        end else begin
            m_left[i] = 0;
        end
    endtask

    task automatic check(input string name, input exp_t exp, input exp_t act);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got bus=%h vld=%b busy=%b conf=%b want bus=%h vld=%b busy=%b conf=%b",
                     name, $time, act.bus, act.vld, act.busy, act.conf,
                     exp.bus, exp.vld, exp.busy, exp.conf);
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic step(input bit rst, input bit req, input logic [15:0] din,
                        input logic [15:0] g, input logic [127:0] regr,
                        input logic [7:0] rout, input bit gout, input bit dinout);
        exp_t e;
        @(negedge Clock);
        Resetn = rst; ReqRead = req; DIN = din; G = g; RegR = regr;
        Rout = rout; Gout = gout; DINout = dinout;
        for (int i = 0; i < 2; i++) begin
            model_edge(i, rst, req, din, g, regr, rout, gout, dinout);
            e.bus  = m_bus[i];
            e.vld  = (m_left[i] > 0);
            e.busy = (m_left[i] > 0);
            e.conf = m_conf[i];
            if (i == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        if (!rst) begin
            #1;
            check("async_reset_a", exp_t'(19'h0), {bus_a, vld_a, busy_a, conf_a});
            check("async_reset_b", exp_t'(19'h0), {bus_b, vld_b, busy_b, conf_b});
        end
    endtask

    // Monitor: after each rising edge compare both instances against the scoreboard.
    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("hold1", e, {bus_a, vld_a, busy_a, conf_a});
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("hold3", e, {bus_b, vld_b, busy_b, conf_b});
        end
    end

    logic [127:0] regr_v;
    logic [7:0]   rout_v;
    bit           req_v, gout_v, din_v, rst_v;
    int           kind;

    initial begin
        Resetn = 1'b0; ReqRead = 1'b0; DIN = '0; G = '0; RegR = '0;
        Rout = '0; Gout = 1'b0; DINout = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_bus[i] = 16'h0; m_left[i] = 0; m_conf[i] = 1'b0;
        end

        // Reset held with random inputs on every port
        for (int c = 0; c < 3; c++)
            step(1'b0, 1'b1, 16'($urandom), 16'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), 1'b1, 1'b1);

        // R3 = 00A5 selected for a single request, then idle
        regr_v = '0;
        regr_v[3*16 +: 16] = 16'h00A5;
        step(1'b1, 1'b1, 16'h0, 16'h0, regr_v, 8'b0000_1000, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 16'h0, 16'h0, regr_v, 8'h00, 1'b0, 1'b0);

        // G = 1234 captured, then G changes to FFFF while the snapshot is held
        step(1'b1, 1'b1, 16'h0, 16'h1234, '0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h0, 16'hFFFF, '0, 8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 16'h0, 16'hFFFF, '0, 8'h00, 1'b0, 1'b0);

        // Back-to-back: DIN = 0011 then R7 = 0022 with ReqRead held
        regr_v = '0;
        regr_v[7*16 +: 16] = 16'h0022;
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 16'h0011, 16'h0, regr_v, 8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 16'h0011, 16'h0, regr_v, 8'h80, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 16'h0011, 16'h0, regr_v, 8'h00, 1'b0, 1'b0);

        // DINout and Rout[0] together: DIN wins, conflict flag is sticky when enabled
        regr_v = '0;
        regr_v[0 +: 16] = 16'h0BAD;
        step(1'b1, 1'b1, 16'h7777, 16'h0, regr_v, 8'h01, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 16'h7777, 16'h0, regr_v, 8'h00, 1'b0, 1'b0);

        // Reset mid-DRIVE, then a request without any select is ignored
        step(1'b1, 1'b1, 16'h5A5A, 16'h0, '0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h5A5A, 16'h0, '0, 8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 16'h5A5A, 16'h1111, '0, 8'h00, 1'b0, 1'b0);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            rst_v  = ($urandom_range(0, 49) != 0);
            req_v  = ($urandom_range(0, 3) != 0);
            regr_v = {$urandom, $urandom, $urandom, $urandom};
            rout_v = 8'h00; gout_v = 1'b0; din_v = 1'b0;
            kind   = int'($urandom_range(0, 9));
            case (kind)
                0: ;
                1: din_v = 1'b1;
                2: gout_v = 1'b1;
                8: begin rout_v = 8'($urandom); gout_v = 1'($urandom); din_v = 1'($urandom); end
                9: begin din_v = 1'b1; rout_v = 8'h1 << $urandom_range(0, 7); end
                default: rout_v = 8'h1 << $urandom_range(0, 7);
            endcase
            step(rst_v, req_v, 16'($urandom), 16'($urandom), regr_v, rout_v, gout_v, din_v);
        end

        // Drain the scoreboard; anything left over means the monitor missed a cycle
        @(posedge Clock);
        @(posedge Clock);
        #2;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d entries left want 0/0", q_a.size(), q_b.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
